bcd4digit: RTL and testbench

- Sequential binary-to-BCD converter for the 4-digit 7-segment display path.
- Samples a 14-bit unsigned binary value and converts it with the shift-and-add-3 (double-dabble) algorithm.
- Presents four registered BCD digits to the display multiplexer: A is thousands, B hundreds, C tens, D units.
- Runs continuously and refreshes its outputs once every conversion frame.

---
 rtl/bcd4digit.sv | 80 ++++++++
 tb/tb_bcd4digit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/bcd4digit.sv
// Free-running binary-to-BCD converter for the 4-digit display.
// Each 16-clock frame samples the input, runs shift-and-add-3 on it, then updates the digit registers.
module bcd4digit #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned MAXVAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [3:0]       C,
    output logic [3:0]       D
);

    typedef enum logic [1:0] {StLoad, StShift, StDone} state_t;

    localparam logic [WIDTH-1:0] MaxCode = WIDTH'(MAXVAL);
    localparam logic [3:0]       LastBit = 4'(WIDTH - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] bin;
    logic [15:0]      scratch;
    logic [15:0]      adjusted;
    logic [WIDTH-1:0] sampled;

    // Add-3 correction on every nibble, applied before the shift.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                adjusted[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        sampled = (value > MaxCode) ? MaxCode : value;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StLoad;
            cnt     <= 4'd0;
            bin     <= '0;
            scratch <= '0;
            A       <= 4'd0;
            B       <= 4'd0;
            C       <= 4'd0;
            D       <= 4'd0;
        end else begin
            unique case (state)
                StLoad: begin
                    bin     <= sampled;
                    scratch <= '0;
                    cnt     <= 4'd0;
                    state   <= StShift;
                end
                StShift: begin
                    scratch <= {adjusted[14:0], bin[WIDTH-1]};
                    bin     <= {bin[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 4'd1;
                    if (cnt == LastBit) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    A     <= scratch[15:12];
                    B     <= scratch[11:8];
                    C     <= scratch[7:4];
                    D     <= scratch[3:0];
                    state <= StLoad;
                end
                default: state <= StLoad;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd4digit.sv
// Directed bench for bcd4digit: reset, frame timing, saturation, boundaries,
// a strided sweep of the decimal range and reset during a conversion.
module tb_bcd4digit;

    logic        clk;
    logic        rst;
    logic [13:0] value;
    logic [3:0]  A, B, C, D;

    int n_checks;
    int n_fails;

    bcd4digit dut (
        .clk   (clk),
        .rst   (rst),
        .value (value),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {A, B, C, D};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then park on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after an output-update edge: next edge is the sampling edge.
    task automatic frame(input string tag, input int v, input logic [15:0] exp);
        value = 14'(v);
        tick(16);
        check(tag, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst      = 1'b1;
        value    = 14'd351;

        #20;
        check("reset_async", 16'h0000);
        tick(3);
        check("reset_held", 16'h0000);

        rst = 1'b0;
        tick(15);
        check("edge15_no_output", 16'h0000);
        tick(1);
        check("edge16_first", 16'h0351);
        tick(16);
        check("frame2_stable", 16'h0351);

        // Value changes mid-frame must not affect the frame in progress.
        tick(5);
        value = 14'd10230;
        check("sat_midframe_hold", 16'h0351);
        tick(11);
        check("sat_current_frame", 16'h0351);
        tick(16);
        check("sat_next_frame", 16'h9999);

        frame("zero", 0, 16'h0000);
        frame("max", 9999, 16'h9999);
        frame("all_ones", 16383, 16'h9999);
        frame("thousand", 1000, 16'h1000);
        frame("nine", 9, 16'h0009);
        frame("mixed", 4096, 16'h4096);

        for (int v = 0; v <= 9999; v += 7) begin
            value = 14'(v);
            tick(16);
            check("sweep", to_bcd(v));
            n_checks++;
            assert (A <= 4'd9 && B <= 4'd9 && C <= 4'd9 && D <= 4'd9) else begin
                n_fails++;
                $error("FAIL sweep_range: observed %h%h%h%h expected all nibbles <= 9",
                       A, B, C, D);
            end
        end
        frame("sweep_last", 9998, 16'h9998);

        // Reset during SHIFT: counter is 7 after the 8th edge past the last update.
        value = 14'd4821;
        tick(8);
        check("pre_abort", 16'h9998);
        rst = 1'b1;
        #1;
        check("abort_async", 16'h0000);
        tick(2);
        check("abort_held", 16'h0000);
        rst = 1'b0;
        tick(15);
        check("abort_edge15", 16'h0000);
        tick(1);
        check("abort_edge16", 16'h4821);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
